pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 9, width of the program counter.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1..7, number of cycles flush_o is held after a redirect.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port stall, input, 1, hazard stall; holds the PC.
REQ-006 Port br_taken, input, 1, branch/jump redirect request (branch-unit select).
REQ-007 Port br_target, input, 32, redirect target address.
REQ-008 Port halt_req, input, 1, request to stop fetching.
REQ-009 Port resume, input, 1, leave the halted state.
REQ-010 Port pc, output, PC_W, current fetch address (registered).
REQ-011 Port if_valid, output, 1, fetch at pc is valid.
REQ-012 Port flush, output, 1, squash younger IF/ID instructions.
REQ-013 Port halted, output, 1, sequencer is in HALTED.
REQ-014 Port br_count, output, 16, taken-redirect count; present only under REQ-031.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, FLUSH and HALTED.
REQ-016 In RUN with no event, pc SHALL advance by 4 each cycle, modulo 2^PC_W (wrap to 0 after 2^PC_W-4).
REQ-017 In RUN with stall=1 and no other event, pc SHALL hold its value.
REQ-018 On br_taken=1 in RUN, next pc SHALL be br_target[PC_W-1:0] with bits [1:0] forced to 0; bits above PC_W are ignored. The state goes to FLUSH with counter=FLUSH_CYCLES-1.
REQ-019 br_taken SHALL override stall and halt_req in the same cycle; halt_req is dropped, not queued.
REQ-020 While in FLUSH, flush SHALL be 1 and pc SHALL advance by 4 unless stall=1. The counter decrements each cycle. FLUSH returns to RUN in the cycle after the counter reads 0, so flush is high exactly FLUSH_CYCLES cycles.
REQ-021 br_taken and halt_req SHALL be ignored while in FLUSH, because they come from squashed instructions.
REQ-022 On halt_req=1 in RUN with no br_taken, the state SHALL go to HALTED and pc SHALL hold, regardless of stall.
REQ-023 In HALTED: if_valid=0, halted=1, pc held, and stall and br_taken are ignored.
REQ-024 On resume=1 in HALTED, the state SHALL go to RUN and pc SHALL advance by 4 in that same edge; resume outside HALTED has no effect.
REQ-025 if_valid SHALL be 1 in RUN and FLUSH and 0 in HALTED; flush SHALL be 0 outside FLUSH.

Reset
REQ-026 On reset=1 at a clock edge: pc=0, state=RUN, flush counter=0, br_count=0.
REQ-027 reset SHALL take priority over all other inputs, including mid-FLUSH and while HALTED.
REQ-028 In the cycle after reset: if_valid=1, flush=0, halted=0.

Configuration
REQ-029 Macro PC_SEQ_BRANCH_STATS_EN SHALL select the branch-statistics feature.
REQ-030 Without the macro, the br_count port and its counter SHALL be absent.
REQ-031 With the macro, br_count SHALL increment on each accepted redirect (REQ-018 only, not ignored ones) and saturate at 16'hFFFF.

Structure
REQ-032 Package pc_seq_pkg SHALL hold the state enum (RUN, FLUSH, HALTED) and the constant PC_INC=4.
REQ-033 The flush down-counter SHALL be a sub-module named flush_timer, with inputs load/value and outputs busy/done.
REQ-034 Next-state and next-pc logic SHALL be a single combinational block; pc, state and counters are registered.

Verification
REQ-035 Reset, then 5 idle cycles -> pc sequence 0,4,8,12,16,20; if_valid=1; flush=0.
REQ-036 At pc=8, br_taken=1 with br_target=32'h0000_0103 -> next pc=0x100; flush=1 for exactly 2 cycles with pc 0x100 then 0x104; a br_taken pulse during FLUSH is ignored; br_count=1 when enabled.
REQ-037 stall=1 and br_taken=1 in the same RUN cycle, target 0x40 -> pc=0x40 and FLUSH entered; stall alone for 3 cycles at pc=0x20 -> pc stays 0x20.
REQ-038 halt_req=1 at pc=0x10 -> halted=1, if_valid=0, pc=0x10 held for 10 cycles despite br_taken pulses; resume=1 -> pc=0x14, state RUN.
REQ-039 PC_W=9, pc=0x1FC with no events -> next pc=0x000.
REQ-040 reset asserted during the 2nd FLUSH cycle and in HALTED -> next cycle pc=0, flush=0, halted=0, if_valid=1.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int PC_INC        = 4;
  localparam int FLUSH_CNT_W   = 3;
  localparam logic [15:0] BR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/flush_timer.sv
// Down-counter that times the post-redirect flush window; done_o marks the
// terminal count of an armed window, busy_o stays high until that count retires.
module flush_timer
  import pc_seq_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [FLUSH_CNT_W-1:0] value_i,
  output logic                   busy_o,
  output logic                   done_o
);

  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   active_q, active_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load_i) begin
      cnt_d    = value_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
  end

  assign busy_o = active_q;
  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: RUN / FLUSH / HALTED with redirect flush window.
// Optional redirect statistics (br_count_o) under PC_SEQ_BRANCH_STATS_EN.
//
// state  | meaning
// RUN    | fetching, pc advances by PC_INC unless stalled
// FLUSH  | squashing younger IF/ID after a redirect, redirects/halts ignored
// HALTED | fetch stopped, pc held until resume
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W         = 9,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [31:0]     br_target_i,
  input  logic            halt_req_i,
  input  logic            resume_i,
  output logic [PC_W-1:0] pc_o,
  output logic            if_valid_o,
  output logic            flush_o,
  output logic            halted_o
`ifdef PC_SEQ_BRANCH_STATS_EN
  ,
  output logic [15:0]     br_count_o
`endif
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pc_inc, br_pc;
  logic              timer_load, timer_busy, timer_done;

  logic unused_tgt_bits;
  assign unused_tgt_bits = ^{br_target_i[31:PC_W], br_target_i[1:0]};

  assign pc_inc = pc_q + PC_W'(PC_INC);
  assign br_pc  = {br_target_i[PC_W-1:2], 2'b00};

  flush_timer u_flush_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (timer_load),
    .value_i (FLUSH_CNT_W'(FLUSH_CYCLES - 1)),
    .busy_o  (timer_busy),
    .done_o  (timer_done)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    timer_load = 1'b0;
    case (state_q)
      RUN: begin
        if (br_taken_i) begin
          pc_d       = br_pc;
          state_d    = FLUSH;
          timer_load = 1'b1;
        end else if (halt_req_i) begin
          state_d = HALTED;
        end else if (!stall_i) begin
          pc_d = pc_inc;
        end
      end
      FLUSH: begin
        if (!stall_i) pc_d = pc_inc;
        // an unarmed timer must never trap the sequencer in FLUSH
        if (timer_done || !timer_busy) state_d = RUN;
      end
      HALTED: begin
        if (resume_i) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    if_valid_o = (state_q != HALTED);
    flush_o    = (state_q == FLUSH);
    halted_o   = (state_q == HALTED);
  end

  assign pc_o = pc_q;

`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0] br_count_q, br_count_d;
  logic        br_accept;

  assign br_accept = (state_q == RUN) && br_taken_i;

  always_comb begin
    br_count_d = br_count_q;
    if (br_accept && (br_count_q != BR_COUNT_MAX)) br_count_d = br_count_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) br_count_q <= '0;
    else         br_count_q <= br_count_d;
  end

  assign br_count_o = br_count_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer against a behavioural fetch model.
// Build with +define+PC_SEQ_BRANCH_STATS_EN to also check br_count_o.
module tb_pc_sequencer;

  localparam int PC_W         = 9;
  localparam int FLUSH_CYCLES = 2;
  localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b0, stall_i = 1'b0, br_taken_i = 1'b0;
  logic [31:0]     br_target_i = '0;
  logic            halt_req_i = 1'b0, resume_i = 1'b0;
  logic [PC_W-1:0] pc_o;
  logic            if_valid_o, flush_o, halted_o;
`ifdef PC_SEQ_BRANCH_STATS_EN
  logic [15:0]     br_count_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model: plain integers
  int m_pc, m_mode, m_left, m_cnt;

  pc_sequencer #(.PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .halt_req_i  (halt_req_i),
    .resume_i    (resume_i),
    .pc_o        (pc_o),
    .if_valid_o  (if_valid_o),
    .flush_o     (flush_o),
    .halted_o    (halted_o)
`ifdef PC_SEQ_BRANCH_STATS_EN
    ,
    .br_count_o  (br_count_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic int wrap_pc(input int v);
    return v % (1 << PC_W);
  endfunction

  task automatic model_edge(input logic s, b, input logic [31:0] t, input logic h, r, rs);
    if (rs) begin
      m_pc = 0; m_mode = M_RUN; m_left = 0; m_cnt = 0;
    end else if (m_mode == M_RUN) begin
      if (b) begin
        m_pc   = wrap_pc(int'(t & 32'h7FFF_FFFF)) & ~3;
        m_mode = M_FLUSH;
        m_left = FLUSH_CYCLES;
        if (m_cnt < 65535) m_cnt++;
      end else if (h) m_mode = M_HALT;
      else if (!s) m_pc = wrap_pc(m_pc + 4);
    end else if (m_mode == M_FLUSH) begin
      if (!s) m_pc = wrap_pc(m_pc + 4);
      m_left--;
      if (m_left == 0) m_mode = M_RUN;
    end else begin
      if (r) begin
        m_mode = M_RUN;
        m_pc   = wrap_pc(m_pc + 4);
      end
    end
  endtask

  task automatic step(input logic s, b, input logic [31:0] t, input logic h, r, rs);
    stall_i = s; br_taken_i = b; br_target_i = t;
    halt_req_i = h; resume_i = r; reset_i = rs;
    @(posedge clk_i);
    model_edge(s, b, t, h, r, rs);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(0, 0, 32'h0, 0, 0, 1);
    n_checks++;
    if ({pc_o, if_valid_o, flush_o, halted_o} !== {9'h000, 3'b100}) begin
      n_errors++;
      $display("FAIL reset: pc=%h v/f/h=%b%b%b expected pc=000 v/f/h=100",
               pc_o, if_valid_o, flush_o, halted_o);
    end
  endtask

  task automatic test_idle;
    test_reset();
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      n_checks++;
      if (pc_o !== PC_W'(4 * i) || if_valid_o !== 1'b1 || flush_o !== 1'b0) begin
        n_errors++;
        $display("FAIL idle[%0d]: pc=%h v=%b f=%b expected pc=%h v=1 f=0",
                 i, pc_o, if_valid_o, flush_o, 4 * i);
      end
    end
  endtask

  task automatic test_branch;
    test_reset();
    idle(2);
    n_checks++;
    if (pc_o !== 9'h008) begin
      n_errors++; $display("FAIL br_pre: pc=%h expected 008", pc_o);
    end
    step(0, 1, 32'h0000_0103, 0, 0, 0);
    n_checks++;
    if (pc_o !== 9'h100 || flush_o !== 1'b1) begin
      n_errors++; $display("FAIL br_flush1: pc=%h f=%b expected pc=100 f=1", pc_o, flush_o);
    end
    step(0, 1, 32'h0000_0200, 1, 0, 0);
    n_checks++;
    if (pc_o !== 9'h104 || flush_o !== 1'b1 || halted_o !== 1'b0) begin
      n_errors++;
      $display("FAIL br_flush2: pc=%h f=%b h=%b expected pc=104 f=1 h=0", pc_o, flush_o, halted_o);
    end
    idle(1);
    n_checks++;
    if (pc_o !== 9'h108 || flush_o !== 1'b0 || if_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL br_exit: pc=%h f=%b v=%b expected pc=108 f=0 v=1", pc_o, flush_o, if_valid_o);
    end
`ifdef PC_SEQ_BRANCH_STATS_EN
    n_checks++;
    if (br_count_o !== 16'd1) begin
      n_errors++; $display("FAIL br_count: got %0d expected 1", br_count_o);
    end
`endif
  endtask

  task automatic test_stall_branch;
    test_reset();
    idle(3);
    step(1, 1, 32'h0000_0040, 0, 0, 0);
    n_checks++;
    if (pc_o !== 9'h040 || flush_o !== 1'b1) begin
      n_errors++; $display("FAIL stall_br: pc=%h f=%b expected pc=040 f=1", pc_o, flush_o);
    end
    test_reset();
    idle(8);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 32'h0, 0, 0, 0);
      n_checks++;
      if (pc_o !== 9'h020 || flush_o !== 1'b0) begin
        n_errors++; $display("FAIL stall_hold[%0d]: pc=%h expected 020", i, pc_o);
      end
    end
  endtask

  task automatic test_halt;
    test_reset();
    idle(4);
    step($urandom_range(1), 0, 32'h0, 1, 0, 0);
    n_checks++;
    if (pc_o !== 9'h010 || halted_o !== 1'b1 || if_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_enter: pc=%h h=%b v=%b expected pc=010 h=1 v=0", pc_o, halted_o, if_valid_o);
    end
    for (int i = 0; i < 10; i++) begin
      step($urandom_range(1), $urandom_range(1), $urandom, 0, 0, 0);
      n_checks++;
      if (pc_o !== 9'h010 || halted_o !== 1'b1 || if_valid_o !== 1'b0 || flush_o !== 1'b0) begin
        n_errors++; $display("FAIL halt_hold[%0d]: pc=%h h=%b expected pc=010 h=1", i, pc_o, halted_o);
      end
    end
    step(0, 0, 32'h0, 0, 1, 0);
    n_checks++;
    if (pc_o !== 9'h014 || halted_o !== 1'b0 || if_valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL resume: pc=%h h=%b v=%b expected pc=014 h=0 v=1", pc_o, halted_o, if_valid_o);
    end
  endtask

  task automatic test_wrap;
    test_reset();
    step(0, 1, 32'hFFFF_FFF4, 0, 0, 0);
    idle(2);
    n_checks++;
    if (pc_o !== 9'h1FC || flush_o !== 1'b0) begin
      n_errors++; $display("FAIL wrap_pre: pc=%h f=%b expected pc=1fc f=0", pc_o, flush_o);
    end
    idle(1);
    n_checks++;
    if (pc_o !== 9'h000) begin
      n_errors++; $display("FAIL wrap: pc=%h expected 000", pc_o);
    end
  endtask

  task automatic test_reset_priority;
    test_reset();
    step(0, 1, 32'h0000_0080, 0, 0, 0);
    step(0, 1, 32'h0000_0300, 1, 1, 1);
    n_checks++;
    if ({pc_o, if_valid_o, flush_o, halted_o} !== {9'h000, 3'b100}) begin
      n_errors++;
      $display("FAIL rst_flush: pc=%h v/f/h=%b%b%b expected pc=000 v/f/h=100",
               pc_o, if_valid_o, flush_o, halted_o);
    end
    idle(2);
    step(0, 0, 32'h0, 1, 0, 0);
    step(0, 0, 32'h0, 0, 1, 1);
    n_checks++;
    if ({pc_o, if_valid_o, flush_o, halted_o} !== {9'h000, 3'b100}) begin
      n_errors++;
      $display("FAIL rst_halt: pc=%h v/f/h=%b%b%b expected pc=000 v/f/h=100",
               pc_o, if_valid_o, flush_o, halted_o);
    end
  endtask

  task automatic test_random;
    logic [PC_W-1:0] exp_pc;
    logic [2:0]      exp_flags;
    test_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3) == 0, $urandom_range(5) == 0, $urandom,
           $urandom_range(9) == 0, $urandom_range(2) == 0, $urandom_range(63) == 0);
      exp_pc    = PC_W'(m_pc);
      exp_flags = {m_mode != M_HALT, m_mode == M_FLUSH, m_mode == M_HALT};
      n_checks++;
      if ({pc_o, if_valid_o, flush_o, halted_o} !== {exp_pc, exp_flags}) begin
        n_errors++;
        $display("FAIL random[%0d]: pc=%h v/f/h=%b%b%b expected pc=%h v/f/h=%b",
                 i, pc_o, if_valid_o, flush_o, halted_o, exp_pc, exp_flags);
      end
`ifdef PC_SEQ_BRANCH_STATS_EN
      n_checks++;
      if (br_count_o !== 16'(m_cnt)) begin
        n_errors++; $display("FAIL random_cnt[%0d]: got %0d expected %0d", i, br_count_o, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_branch();
    test_stall_branch();
    test_halt();
    test_wrap();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
